// File: rtl/cpu_step_controller.sv
// -----------------------------------------------------------------------------
// cpu_step_controller
//
// Run/single-step controller for a soft CPU. A raw push button is synchronized,
// debounced and edge-detected into a one-cycle step request; a run switch
// selects free-running mode. A small FSM turns these into a CPU clock enable.
// A saturating counter tracks enabled cycles, and an activity LED stays lit
// for a short hold time after the last enable.
//
// Ports
//   myClk     in   sole clock, rising edge
//   rst       in   asynchronous active-low reset
//   step_btn  in   raw bouncing step button (1 = pressed)
//   run_sw    in   raw run/step switch (1 = free-run requested)
//   halt_req  in   synchronous level halt request from the CPU
//   cnt_clr   in   synchronous clear of step_cnt (wins over increment)
//   cpu_ce    out  CPU clock enable (combinational from state and inputs)
//   step_led  out  activity LED, registered
//   state     out  FSM code: HALT=0, STEP=1, RUN=2, WAIT_REL=3
//   step_cnt  out  saturating count of cycles with cpu_ce=1
// -----------------------------------------------------------------------------
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LED_HOLD        = 3,
    parameter int CNT_W           = 16
) (
    input  logic             myClk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             cpu_ce,
    output logic             step_led,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_cnt
);

    typedef enum logic [1:0] {
        S_HALT     = 2'd0,
        S_STEP     = 2'd1,
        S_RUN      = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    localparam logic [7:0]       DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       LED_LOAD = 8'(LED_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // Two-flop synchronizers. Bit 0 = step button, bit 1 = run switch.
    // -------------------------------------------------------------------------
    logic [1:0] raw_in;
    logic [1:0] sync_meta_reg;
    logic [1:0] sync_reg;

    assign raw_in = {run_sw, step_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge myClk or negedge rst) begin
                if (!rst) begin
                    sync_meta_reg[gi] <= 1'b0;
                    sync_reg[gi]      <= 1'b0;
                end else begin
                    sync_meta_reg[gi] <= raw_in[gi];
                    sync_reg[gi]      <= sync_meta_reg[gi];
                end
            end
        end
    endgenerate

    logic btn_s;
    logic run_sw_s;

    assign btn_s    = sync_reg[0];
    assign run_sw_s = sync_reg[1];

    // -------------------------------------------------------------------------
    // Debouncer: the accepted level only flips after DEBOUNCE_CYCLES samples in
    // a row disagree with it. A sample that agrees restarts the count.
    // -------------------------------------------------------------------------
    logic       db_level_reg;
    logic       db_level_next;
    logic [7:0] db_cnt_reg;
    logic [7:0] db_cnt_next;
    logic       db_prev_reg;
    logic       step_req;

    always_comb begin
        db_level_next = db_level_reg;
        db_cnt_next   = 8'd0;
        if (btn_s != db_level_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                db_level_next = btn_s;
                db_cnt_next   = 8'd0;
            end else begin
                db_cnt_next = db_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge myClk or negedge rst) begin
        if (!rst) begin
            db_level_reg <= 1'b0;
            db_cnt_reg   <= 8'd0;
            db_prev_reg  <= 1'b0;
        end else begin
            db_level_reg <= db_level_next;
            db_cnt_reg   <= db_cnt_next;
            db_prev_reg  <= db_level_reg;
        end
    end

    // One-cycle pulse on each debounced rising edge. Both flops reset to 0, so
    // a button held through reset only steps once its debounced rise is seen.
    assign step_req = db_level_reg & ~db_prev_reg;

    // -------------------------------------------------------------------------
    // Control FSM: state register / next-state logic / output logic.
    // -------------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   halt_lat_reg;
    logic   halt_lat_next;
    logic   run_ok;

    // Free-run is only permitted once a breakpoint halt has been acknowledged
    // by taking the switch back to 0.
    assign run_ok = run_sw_s & ~halt_req & ~halt_lat_reg;

    always_ff @(posedge myClk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_HALT;
            halt_lat_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            halt_lat_reg <= halt_lat_next;
        end
    end

    always_comb begin
        halt_lat_next = halt_lat_reg;
        if (!run_sw_s) begin
            halt_lat_next = 1'b0;
        end else if (state_reg == S_RUN && halt_req) begin
            halt_lat_next = 1'b1;
        end
    end

    // Step requests outside HALT fall through every branch below and are lost,
    // which is the intended discard behaviour.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_HALT: begin
                if (run_ok) begin
                    state_next = S_RUN;
                end else if (step_req) begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                state_next = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!db_level_reg) begin
                    state_next = S_HALT;
                end
            end
            S_RUN: begin
                if (!run_sw_s || halt_req) begin
                    state_next = S_HALT;
                end
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    // The enable is gated with the live halt_req/run_sw_s so that the CPU does
    // not advance on the cycle a halt is requested.
    always_comb begin
        cpu_ce = 1'b0;
        case (state_reg)
            S_STEP:  cpu_ce = 1'b1;
            S_RUN:   cpu_ce = run_sw_s & ~halt_req;
            default: cpu_ce = 1'b0;
        endcase
        state = state_reg;
    end

    // -------------------------------------------------------------------------
    // Enabled-cycle counter, saturating; clear has priority.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] step_cnt_reg;
    logic [CNT_W-1:0] step_cnt_next;

    always_comb begin
        step_cnt_next = step_cnt_reg;
        if (cnt_clr) begin
            step_cnt_next = '0;
        end else if (cpu_ce && step_cnt_reg != CNT_MAX) begin
            step_cnt_next = step_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge myClk or negedge rst) begin
        if (!rst) begin
            step_cnt_reg <= '0;
        end else begin
            step_cnt_reg <= step_cnt_next;
        end
    end

    assign step_cnt = step_cnt_reg;

    // -------------------------------------------------------------------------
    // Activity LED: reload the hold counter on every enabled cycle and let it
    // run down afterwards. The LED flop mirrors the counter's next value so it
    // lights on the same edge the counter is loaded.
    // -------------------------------------------------------------------------
    logic [7:0] led_cnt_reg;
    logic [7:0] led_cnt_next;
    logic       step_led_reg;

    always_comb begin
        led_cnt_next = led_cnt_reg;
        if (cpu_ce) begin
            led_cnt_next = LED_LOAD;
        end else if (led_cnt_reg != 8'd0) begin
            led_cnt_next = led_cnt_reg - 8'd1;
        end
    end

    always_ff @(posedge myClk or negedge rst) begin
        if (!rst) begin
            led_cnt_reg  <= 8'd0;
            step_led_reg <= 1'b0;
        end else begin
            led_cnt_reg  <= led_cnt_next;
            step_led_reg <= (led_cnt_next != 8'd0);
        end
    end

    assign step_led = step_led_reg;

endmodule

// File: doc/cpu_step_controller.md
CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive equal synchronized samples needed to accept a new button level (range 1..255).
REQ-002 Parameter LED_HOLD, default 3: cycles step_led stays lit after the last CPU enable (range 1..255).
REQ-003 Parameter CNT_W, default 16: width of step_cnt.
REQ-004 myClk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-006 step_btn  in  1  raw, asynchronous, bouncing single-step push button; high = pressed.
REQ-007 run_sw  in  1  asynchronous run/step mode switch; 1 = free-run requested.
REQ-008 halt_req  in  1  synchronous halt request from the CPU (breakpoint/syscall), level.
REQ-009 cnt_clr  in  1  synchronous clear of step_cnt.
REQ-010 cpu_ce  out  1  CPU clock enable; CPU advances one instruction per cycle it is high.
REQ-011 step_led  out  1  activity LED.
REQ-012 state  out  2  FSM state code: HALT=0, STEP=1, RUN=2, WAIT_REL=3.
REQ-013 step_cnt  out  CNT_W  count of cycles with cpu_ce=1.

Function
REQ-014 step_btn and run_sw SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 The synchronized step_btn SHALL update its debounced level only after DEBOUNCE_CYCLES consecutive identical samples differing from the current level; any mismatch restarts the count.
REQ-016 step_req SHALL be a one-cycle internal pulse on each 0->1 transition of the debounced button.
REQ-017 The FSM SHALL implement the following transitions:
- HALT -> RUN when run_sw_s=1, halt_req=0, halt_lat=0.
- HALT -> STEP when step_req=1 and the RUN condition is false (RUN wins if both hold).
- STEP -> WAIT_REL unconditionally after one cycle.
- WAIT_REL -> HALT when the debounced button is 0; run_sw is ignored in WAIT_REL.
- RUN -> HALT when run_sw_s=0 or halt_req=1.
REQ-018 cpu_ce SHALL be combinational: 1 when state=STEP, or when state=RUN and halt_req=0 and run_sw_s=1; otherwise 0.
REQ-019 Each accepted button press SHALL produce exactly one cpu_ce cycle, regardless of press duration or bounce.
REQ-020 halt_lat SHALL be set when RUN exits because halt_req=1, and SHALL be cleared while run_sw_s=0; resuming after a halt requires run_sw to go 0 then 1.
REQ-021 Single-stepping SHALL be allowed while halt_req=1 or halt_lat=1.
REQ-022 step_cnt SHALL increment by 1 on every cycle with cpu_ce=1 and saturate at 2^CNT_W-1; cnt_clr=1 SHALL clear it to 0 and take priority over the increment.
REQ-023 led_cnt SHALL load LED_HOLD on any cycle with cpu_ce=1, otherwise decrement toward 0 and stop at 0; step_led = (led_cnt != 0), registered.
REQ-024 step_req arriving in STEP, WAIT_REL or RUN SHALL be discarded, not queued.

Reset
REQ-025 While rst=0: state=HALT, cpu_ce=0, step_led=0, step_cnt=0, halt_lat=0, synchronizers=0, debounced level=0, debounce and LED counters=0.
REQ-026 Reset deassertion SHALL be the only exit from reset; the first edge after rst=1 evaluates from HALT.
REQ-027 A button held through reset release SHALL produce one step only after its debounced rise is seen (debounced level starts at 0).
REQ-028 Reset asserted mid-STEP or mid-RUN SHALL drop cpu_ce to 0 asynchronously.

Verification
REQ-029 Clean press of 10 cycles, defaults -> exactly one cpu_ce pulse about 2+4 cycles after press; step_cnt=1; step_led high 3 cycles; state returns to HALT after release is debounced.
REQ-030 Bouncy press (toggle every cycle for 6 cycles, then steady high for 20) -> exactly one cpu_ce pulse; step_cnt=1.
REQ-031 run_sw=1 for 50 cycles, then 0 -> cpu_ce high continuously from the RUN cycle; step_cnt=cycles in RUN; HALT within 3 cycles of the switch falling; step_led off 3 cycles after the last cpu_ce.
REQ-032 In RUN, halt_req=1 for one cycle -> cpu_ce=0 that cycle, HALT next, halt_lat=1; run_sw held 1 stays in HALT; run_sw 0->1 -> RUN again.
REQ-033 CNT_W=4, 17 steps -> step_cnt saturates at 15; cnt_clr together with cpu_ce -> step_cnt=0.
REQ-034 rst=0 asserted while in RUN -> cpu_ce=0 and step_cnt=0 immediately; after release, state=HALT with no spurious pulse.
